// File: rtl/enigma_merge_if.sv
// Port bundle for the enigma two-to-one flit merger: inputs A and B, output C and status.
interface enigma_merge_if;
  logic [127:0] payload_a;
  logic [4:0]   id_a;
  logic [1:0]   qos_a;
  logic         valid_a;
  logic         ready_a;
  logic [127:0] payload_b;
  logic [4:0]   id_b;
  logic [1:0]   qos_b;
  logic         valid_b;
  logic         ready_b;
  logic [127:0] payload_c;
  logic [5:0]   id_c;
  logic [1:0]   qos_c;
  logic         valid_c;
  logic         ready_c;
  logic         conflict_c;
  logic         release_c;
  logic [5:0]   releaseid_c;
  logic         proto_err;

  modport slave (
    input  payload_a, id_a, qos_a, valid_a,
    output ready_a,
    input  payload_b, id_b, qos_b, valid_b,
    output ready_b,
    output payload_c, id_c, qos_c, valid_c,
    input  ready_c, conflict_c, release_c, releaseid_c,
    output proto_err
  );

  modport master (
    output payload_a, id_a, qos_a, valid_a,
    input  ready_a,
    output payload_b, id_b, qos_b, valid_b,
    input  ready_b,
    input  payload_c, id_c, qos_c, valid_c,
    output ready_c, conflict_c, release_c, releaseid_c,
    input  proto_err
  );
endinterface

// File: rtl/enigma_merge.sv
// Merges flit ports A/B onto registered port C; flits rejected downstream are parked and re-issued on release.
// Optional feature macro: ENIGMA_STARVE_GUARD_EN (per-source starvation counters overriding qos).
module enigma_merge #(
  parameter int unsigned RETRY_DEPTH = 4,
  parameter bit          RR_INIT     = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  enigma_merge_if.slave m_if
);
  localparam int unsigned PW = 128;
  localparam int unsigned IW = 6;
  localparam int unsigned QW = 2;
  localparam int unsigned CW = $clog2(RETRY_DEPTH + 2) + 1;
  localparam int unsigned XW = (RETRY_DEPTH > 1) ? $clog2(RETRY_DEPTH) : 1;

  typedef struct packed {
    logic [PW-1:0] payload;
    logic [IW-1:0] id;
    logic [QW-1:0] qos;
  } flit_t;

  flit_t                  oreg_q, oreg_d, shadow_q, flit_a, flit_b;
  logic                   valid_q, valid_d, hs_d1_q, rr_q, rr_d, err_q, err_d;
  logic [RETRY_DEPTH-1:0] ent_vld_q, ent_vld_d, ent_rel_q, ent_rel_d;
  flit_t                  ent_q [RETRY_DEPTH];

  logic [CW-1:0] occ;
  logic          rel_pend, free_ok, mat_ok, park;
  logic [XW-1:0] rel_idx, free_idx, mat_idx;
  logic          a_wins, grant_a, grant_b, loadable, gate, rdy_a, rdy_b, ab_fire;

`ifdef ENIGMA_STARVE_GUARD_EN
  logic [3:0] starve_a_q, starve_a_d, starve_b_q, starve_b_d;
`endif

  assign flit_a = '{payload: m_if.payload_a, id: {1'b0, m_if.id_a}, qos: m_if.qos_a};
  assign flit_b = '{payload: m_if.payload_b, id: {1'b1, m_if.id_b}, qos: m_if.qos_b};

  // Retry buffer scan; descending so the lowest matching index is the one left selected.
  always_comb begin
    occ      = '0;
    rel_pend = 1'b0;
    rel_idx  = '0;
    free_ok  = 1'b0;
    free_idx = '0;
    mat_ok   = 1'b0;
    mat_idx  = '0;
    for (int i = int'(RETRY_DEPTH) - 1; i >= 0; i--) begin
      if (ent_vld_q[i]) occ = occ + CW'(1);
      if (ent_vld_q[i] && ent_rel_q[i]) begin
        rel_pend = 1'b1;
        rel_idx  = XW'(i);
      end
      if (!ent_vld_q[i]) begin
        free_ok  = 1'b1;
        free_idx = XW'(i);
      end
      if (ent_vld_q[i] && !ent_rel_q[i] && (ent_q[i].id == m_if.releaseid_c)) begin
        mat_ok  = 1'b1;
        mat_idx = XW'(i);
      end
    end
  end

  // A/B arbitration: qos first, round-robin on ties, starvation override when enabled.
  always_comb begin
    a_wins = (rr_q == 1'b0);
    if (m_if.qos_a > m_if.qos_b)      a_wins = 1'b1;
    else if (m_if.qos_b > m_if.qos_a) a_wins = 1'b0;
`ifdef ENIGMA_STARVE_GUARD_EN
    if (starve_a_q == 4'hF && starve_b_q != 4'hF)      a_wins = 1'b1;
    else if (starve_b_q == 4'hF && starve_a_q != 4'hF) a_wins = 1'b0;
`endif
    grant_a = m_if.valid_a && (!m_if.valid_b || a_wins);
    grant_b = m_if.valid_b && (!m_if.valid_a || !a_wins);
  end

  assign loadable = !valid_q || m_if.ready_c;
  assign gate     = (occ + CW'(hs_d1_q) + CW'(1)) <= CW'(RETRY_DEPTH);
  assign rdy_a    = loadable && gate && !rel_pend && grant_a;
  assign rdy_b    = loadable && gate && !rel_pend && grant_b;
  assign ab_fire  = rdy_a || rdy_b;

  assign m_if.ready_a   = rdy_a;
  assign m_if.ready_b   = rdy_b;
  assign m_if.payload_c = oreg_q.payload;
  assign m_if.id_c      = oreg_q.id;
  assign m_if.qos_c     = oreg_q.qos;
  assign m_if.valid_c   = valid_q;
  assign m_if.proto_err = err_q;

  // Output load, conflict parking and release marking.
  always_comb begin
    oreg_d    = oreg_q;
    valid_d   = valid_q;
    rr_d      = rr_q;
    err_d     = err_q;
    ent_vld_d = ent_vld_q;
    ent_rel_d = ent_rel_q;
    park      = 1'b0;

    if (loadable) begin
      if (rel_pend) begin
        oreg_d             = ent_q[rel_idx];
        valid_d            = 1'b1;
        ent_vld_d[rel_idx] = 1'b0;
        ent_rel_d[rel_idx] = 1'b0;
      end else if (ab_fire) begin
        oreg_d  = grant_a ? flit_a : flit_b;
        valid_d = 1'b1;
        rr_d    = grant_a;
      end else begin
        valid_d = 1'b0;
      end
    end

    if (m_if.release_c) begin
      if (mat_ok) ent_rel_d[mat_idx] = 1'b1;
      else        err_d = 1'b1;
    end

    // Parking uses a slot free in registered state, so a slot freed this cycle is reused next cycle.
    if (m_if.conflict_c) begin
      if (hs_d1_q && free_ok) begin
        park                = 1'b1;
        ent_vld_d[free_idx] = 1'b1;
        ent_rel_d[free_idx] = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oreg_q    <= '0;
      valid_q   <= 1'b0;
      hs_d1_q   <= 1'b0;
      rr_q      <= RR_INIT;
      err_q     <= 1'b0;
      ent_vld_q <= '0;
      ent_rel_q <= '0;
    end else begin
      oreg_q    <= oreg_d;
      valid_q   <= valid_d;
      hs_d1_q   <= valid_q && m_if.ready_c;
      rr_q      <= rr_d;
      err_q     <= err_d;
      ent_vld_q <= ent_vld_d;
      ent_rel_q <= ent_rel_d;
    end
  end

  // Flit storage is qualified by the valid bits and needs no reset.
  always_ff @(posedge clk) begin
    if (valid_q && m_if.ready_c) shadow_q <= oreg_q;
    if (park) ent_q[free_idx] <= shadow_q;
  end

`ifdef ENIGMA_STARVE_GUARD_EN
  always_comb begin
    starve_a_d = starve_a_q;
    starve_b_d = starve_b_q;
    if (ab_fire) begin
      if (grant_a)                                  starve_a_d = '0;
      else if (m_if.valid_a && starve_a_q != 4'hF)  starve_a_d = starve_a_q + 4'd1;
      if (grant_b)                                  starve_b_d = '0;
      else if (m_if.valid_b && starve_b_q != 4'hF)  starve_b_d = starve_b_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_a_q <= '0;
      starve_b_q <= '0;
    end else begin
      starve_a_q <= starve_a_d;
      starve_b_q <= starve_b_d;
    end
  end
`endif
endmodule

// File: tb/tb_enigma_merge.sv
// Scoreboard bench for enigma_merge: arbitration, retry parking/release, buffer-full gate, errors, reset.
module tb_enigma_merge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  enigma_merge_if bus();
  enigma_merge #(.RETRY_DEPTH(4), .RR_INIT(1'b0)) dut (.clk(clk), .rst_n(rst_n), .m_if(bus));

  logic [135:0] sb_q[$];
  int n_run = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [135:0] mk(input logic src, input logic [4:0] id,
                                      input logic [1:0] qos, input logic [127:0] pl);
    return {pl, src, id, qos};
  endfunction

  function automatic logic [127:0] pl(input int k);
    return {4{32'hA5A5_0000 | 32'(k)}};
  endfunction

  task automatic set_a(input logic v, input logic [4:0] id, input logic [1:0] qos, input logic [127:0] p);
    bus.valid_a = v; bus.id_a = id; bus.qos_a = qos; bus.payload_a = p;
  endtask

  task automatic set_b(input logic v, input logic [4:0] id, input logic [1:0] qos, input logic [127:0] p);
    bus.valid_b = v; bus.id_b = id; bus.qos_b = qos; bus.payload_b = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    set_a(1'b0, '0, '0, '0);
    set_b(1'b0, '0, '0, '0);
    bus.ready_c = 1'b0; bus.conflict_c = 1'b0; bus.release_c = 1'b0; bus.releaseid_c = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.ready_c = 1'b1;
  endtask

  // Output monitor: every C handshake must match the next expected flit.
  always @(negedge clk) begin
    if (rst_n && bus.valid_c && bus.ready_c) begin
      if (sb_q.size() == 0) check("sb_extra_valid_c", 136'(bus.valid_c), 136'(0));
      else check("sb_flit", {bus.payload_c, bus.id_c, bus.qos_c}, sb_q.pop_front());
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    logic exp_a;
    int   ia, ib, w;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_c", 136'(bus.valid_c), 136'(0));
    check("rst_ready_a", 136'(bus.ready_a), 136'(0));
    check("rst_ready_b", 136'(bus.ready_b), 136'(0));
    check("rst_proto_err", 136'(bus.proto_err), 136'(0));
    check("rst_oreg", {bus.payload_c, bus.id_c, bus.qos_c}, 136'(0));
    rst_n = 1'b1;
    bus.ready_c = 1'b1;

    // T1: A only
    set_a(1'b1, 5'd5, 2'd1, {16{8'h11}});
    @(negedge clk);
    check("t1_ready_a", 136'(bus.ready_a), 136'(1));
    sb_q.push_back(mk(1'b0, 5'd5, 2'd1, {16{8'h11}}));
    tick();
    set_a(1'b0, '0, '0, '0);
    @(negedge clk);
    check("t1_valid_c", 136'(bus.valid_c), 136'(1));
    check("t1_id_c", 136'(bus.id_c), 136'(6'h05));
    check("t1_qos_c", 136'(bus.qos_c), 136'(1));
    tick();

    // T2a: qos priority, B (3) beats A (2)
    set_a(1'b1, 5'd1, 2'd2, pl(1));
    set_b(1'b1, 5'd2, 2'd3, pl(2));
    @(negedge clk);
    check("t2_qos_ready_b", 136'(bus.ready_b), 136'(1));
    check("t2_qos_ready_a", 136'(bus.ready_a), 136'(0));
    sb_q.push_back(mk(1'b1, 5'd2, 2'd3, pl(2)));
    tick();
    set_b(1'b0, '0, '0, '0);
    @(negedge clk);
    check("t2_qos_then_a", 136'(bus.ready_a), 136'(1));
    sb_q.push_back(mk(1'b0, 5'd1, 2'd2, pl(1)));
    tick();
    set_a(1'b0, '0, '0, '0);
    repeat (3) tick();

    // T2b: equal qos round-robin from RR_INIT=A
    do_reset();
    ia = 0; ib = 0;
    set_a(1'b1, 5'(16 + ia), 2'd1, pl(100 + ia));
    set_b(1'b1, 5'(24 + ib), 2'd1, pl(200 + ib));
    for (int k = 0; k < 4; k++) begin
      exp_a = (k % 2 == 0);
      @(negedge clk);
      check("t2_rr_ready_a", 136'(bus.ready_a), 136'(exp_a));
      check("t2_rr_ready_b", 136'(bus.ready_b), 136'(!exp_a));
      if (exp_a) sb_q.push_back(mk(1'b0, 5'(16 + ia), 2'd1, pl(100 + ia)));
      else       sb_q.push_back(mk(1'b1, 5'(24 + ib), 2'd1, pl(200 + ib)));
      tick();
      if (exp_a) begin ia++; set_a(1'b1, 5'(16 + ia), 2'd1, pl(100 + ia)); end
      else       begin ib++; set_b(1'b1, 5'(24 + ib), 2'd1, pl(200 + ib)); end
    end
    set_a(1'b0, '0, '0, '0);
    set_b(1'b0, '0, '0, '0);
    repeat (3) tick();

    // T3: park on conflict, re-issue on release ahead of pending B
    do_reset();
    set_a(1'b1, 5'd7, 2'd0, pl(7));
    @(negedge clk);
    sb_q.push_back(mk(1'b0, 5'd7, 2'd0, pl(7)));
    tick();
    set_a(1'b0, '0, '0, '0);
    tick();
    bus.conflict_c = 1'b1;
    tick();
    bus.conflict_c = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t3_not_resent", 136'(bus.valid_c), 136'(0));
      tick();
    end
    check("t3_no_err", 136'(bus.proto_err), 136'(0));
    bus.release_c = 1'b1;
    bus.releaseid_c = 6'h07;
    sb_q.push_back(mk(1'b0, 5'd7, 2'd0, pl(7)));
    tick();
    bus.release_c = 1'b0;
    set_b(1'b1, 5'd3, 2'd3, pl(3));
    @(negedge clk);
    check("t3_retry_blocks_b", 136'(bus.ready_b), 136'(0));
    tick();
    @(negedge clk);
    check("t3_retry_valid", 136'(bus.valid_c), 136'(1));
    check("t3_retry_id", 136'(bus.id_c), 136'(6'h07));
    check("t3_b_after_retry", 136'(bus.ready_b), 136'(1));
    sb_q.push_back(mk(1'b1, 5'd3, 2'd3, pl(3)));
    tick();
    set_b(1'b0, '0, '0, '0);
    repeat (2) tick();
    check("t3_err_clear", 136'(bus.proto_err), 136'(0));

    // T4: fill retry buffer with four back-to-back conflicts
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) set_a(1'b1, 5'(8 + i), 2'd0, pl(40 + i));
      else       set_a(1'b0, '0, '0, '0);
      bus.conflict_c = (i >= 2);
      @(negedge clk);
      if (i < 4) begin
        check("t4_fill_ready_a", 136'(bus.ready_a), 136'(1));
        sb_q.push_back(mk(1'b0, 5'(8 + i), 2'd0, pl(40 + i)));
      end
      tick();
    end
    bus.conflict_c = 1'b0;
    set_a(1'b1, 5'd12, 2'd0, pl(50));
    set_b(1'b1, 5'd13, 2'd2, pl(51));
    repeat (3) begin
      @(negedge clk);
      check("t4_full_ready_a", 136'(bus.ready_a), 136'(0));
      check("t4_full_ready_b", 136'(bus.ready_b), 136'(0));
      tick();
    end
    check("t4_full_no_err", 136'(bus.proto_err), 136'(0));
    bus.release_c = 1'b1;
    bus.releaseid_c = 6'h09;
    sb_q.push_back(mk(1'b0, 5'd9, 2'd0, pl(41)));
    @(negedge clk);
    check("t4_rel_cycle_b", 136'(bus.ready_b), 136'(0));
    tick();
    bus.release_c = 1'b0;
    @(negedge clk);
    check("t4_rel_pend_b", 136'(bus.ready_b), 136'(0));
    tick();
    @(negedge clk);
    check("t4_resent_id", 136'(bus.id_c), 136'(6'h09));
    check("t4_resume_b", 136'(bus.ready_b), 136'(1));
    check("t4_resume_a_lose", 136'(bus.ready_a), 136'(0));
    sb_q.push_back(mk(1'b1, 5'd13, 2'd2, pl(51)));
    tick();
    set_b(1'b0, '0, '0, '0);
    w = 0;
    @(negedge clk);
    while (!bus.ready_a && w < 10) begin
      tick();
      @(negedge clk);
      w++;
    end
    check("t4_resume_a", 136'(bus.ready_a), 136'(1));
    sb_q.push_back(mk(1'b0, 5'd12, 2'd0, pl(50)));
    tick();
    set_a(1'b0, '0, '0, '0);
    repeat (3) tick();

    // T5: release of unparked id, sticky error, async reset mid-burst
    bus.release_c = 1'b1;
    bus.releaseid_c = 6'h3F;
    tick();
    bus.release_c = 1'b0;
    @(negedge clk);
    check("t5_rel_unparked_err", 136'(bus.proto_err), 136'(1));
    repeat (3) tick();
    check("t5_err_sticky", 136'(bus.proto_err), 136'(1));
    bus.ready_c = 1'b0;
    set_a(1'b1, 5'd14, 2'd1, pl(60));
    tick();
    set_a(1'b0, '0, '0, '0);
    @(negedge clk);
    check("t5_held_valid", 136'(bus.valid_c), 136'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_async_valid", 136'(bus.valid_c), 136'(0));
    check("t5_rst_async_err", 136'(bus.proto_err), 136'(0));
    tick();
    rst_n = 1'b1;
    bus.ready_c = 1'b1;
    bus.release_c = 1'b1;
    bus.releaseid_c = 6'h08;
    tick();
    bus.release_c = 1'b0;
    @(negedge clk);
    check("t5_buf_empty_err", 136'(bus.proto_err), 136'(1));
    do_reset();
    bus.conflict_c = 1'b1;
    tick();
    bus.conflict_c = 1'b0;
    @(negedge clk);
    check("t5_conflict_nohs_err", 136'(bus.proto_err), 136'(1));

    // T6: B qos 3 continuous vs A qos 0
    do_reset();
    ib = 0;
    set_a(1'b1, 5'd20, 2'd0, pl(70));
    set_b(1'b1, 5'(ib), 2'd3, pl(300 + ib));
    for (int i = 0; i < 17; i++) begin
`ifdef ENIGMA_STARVE_GUARD_EN
      exp_a = (i == 15);
`else
      exp_a = 1'b0;
`endif
      @(negedge clk);
      check("t6_ready_a", 136'(bus.ready_a), 136'(exp_a));
      check("t6_ready_b", 136'(bus.ready_b), 136'(!exp_a));
      if (exp_a) sb_q.push_back(mk(1'b0, 5'd20, 2'd0, pl(70)));
      else       sb_q.push_back(mk(1'b1, 5'(ib), 2'd3, pl(300 + ib)));
      tick();
      if (exp_a) set_a(1'b0, '0, '0, '0);
      else begin ib++; set_b(1'b1, 5'(ib), 2'd3, pl(300 + ib)); end
    end
    set_a(1'b0, '0, '0, '0);
    set_b(1'b0, '0, '0, '0);
    repeat (4) tick();
    check("sb_drain", 136'(sb_q.size()), 136'(0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
